pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V core running the FFT/IFFT kernels. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards and taken branches/jumps resolved in EX. It also runs a small FSM that holds the pipeline while a multicycle EX unit (butterfly multiply / complex MAC) is busy. It drives the ID/EX `pipelineFlush` and `idex_hazarded` inputs plus the stall enables of PC, IF/ID and ID/EX.

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use and taken-redirect handling,
// plus a hold FSM for the multicycle EX unit with timeout abort and a stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs1_addr,
    input  logic [4:0]       ifid_rs2_addr,
    input  logic             ifid_rs1_used,
    input  logic             ifid_rs2_used,
    input  logic             idex_mem_rena,
    input  logic [4:0]       idex_reg_waddr,
    input  logic             ex_branch_taken,
    input  logic             ex_mc_req,
    input  logic             mc_done,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             idex_hazarded,
    output logic             pipelineFlush,
    output logic             exmem_bubble,
    output logic             mc_go,
    output logic             mc_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned TMR_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign rs1_hit  = ifid_rs1_used && (ifid_rs1_addr == idex_reg_waddr);
    assign rs2_hit  = ifid_rs2_used && (ifid_rs2_addr == idex_reg_waddr);
    assign load_use = idex_mem_rena && (idex_reg_waddr != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        idex_stall    = 1'b0;
        idex_hazarded = 1'b0;
        pipelineFlush = 1'b0;
        exmem_bubble  = 1'b0;
        mc_go         = 1'b0;
        if (rst) begin
            pipelineFlush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pipelineFlush = 1'b1;
                    end else if (ex_mc_req) begin
                        mc_go        = 1'b1;
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_stall   = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_stall      = 1'b1;
                        ifid_stall    = 1'b1;
                        idex_hazarded = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                end
                MC_DONE: begin
                    // ex_mc_req is still up for the finishing instruction; it must not relaunch.
                    if (ex_branch_taken) begin
                        pipelineFlush = 1'b1;
                    end else if (load_use) begin
                        pc_stall      = 1'b1;
                        ifid_stall    = 1'b1;
                        idex_hazarded = 1'b1;
                    end
                end
                default: begin
                    pipelineFlush = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            timer     <= '0;
            mc_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            unique case (state)
                RUN: begin
                    if (!ex_branch_taken && ex_mc_req) begin
                        state <= MC_WAIT;
                        timer <= '0;
                    end
                end
                MC_WAIT: begin
                    // A completion arriving on the last allowed cycle wins over the abort.
                    if (mc_done) begin
                        state <= MC_DONE;
                    end else if (timer == TMR_LAST) begin
                        mc_err <= 1'b1;
                        state  <= MC_DONE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                MC_DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vectors push expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ifid_rs1_addr = '0;
    logic [4:0]  ifid_rs2_addr = '0;
    logic        ifid_rs1_used = 1'b0;
    logic        ifid_rs2_used = 1'b0;
    logic        idex_mem_rena = 1'b0;
    logic [4:0]  idex_reg_waddr = '0;
    logic        ex_branch_taken = 1'b0;
    logic        ex_mc_req = 1'b0;
    logic        mc_done = 1'b0;
    logic        pc_stall, ifid_stall, idex_stall, idex_hazarded;
    logic        pipelineFlush, exmem_bubble, mc_go, mc_err;
    logic [31:0] stall_cnt;

    pipe_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifid_rs1_addr(ifid_rs1_addr), .ifid_rs2_addr(ifid_rs2_addr),
        .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
        .idex_mem_rena(idex_mem_rena), .idex_reg_waddr(idex_reg_waddr),
        .ex_branch_taken(ex_branch_taken), .ex_mc_req(ex_mc_req), .mc_done(mc_done),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .idex_hazarded(idex_hazarded), .pipelineFlush(pipelineFlush),
        .exmem_bubble(exmem_bubble), .mc_go(mc_go), .mc_err(mc_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Output flag order: {pc, ifid, idex, hz, flush, bubble, go, err}
    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_FLUSH = 8'b0000_1000;
    localparam logic [7:0] O_LU    = 8'b1101_0000;
    localparam logic [7:0] O_GO    = 8'b1110_0110;
    localparam logic [7:0] O_WAIT  = 8'b1110_0100;
    localparam logic [7:0] O_ERR   = 8'b0000_0001;

    logic [7:0]  exp_o_q[$];
    logic [31:0] exp_c_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;

    task automatic cyc(input string nm, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rena,
                       input logic [4:0] wa, input logic br, input logic req,
                       input logic done, input logic [7:0] o);
        @(posedge clk);
        #1;
        rst = r;
        ifid_rs1_addr = rs1; ifid_rs2_addr = rs2;
        ifid_rs1_used = u1;  ifid_rs2_used = u2;
        idex_mem_rena = rena; idex_reg_waddr = wa;
        ex_branch_taken = br; ex_mc_req = req; mc_done = done;
        if (r) exp_cnt = '0;
        exp_o_q.push_back(o);
        exp_c_q.push_back(exp_cnt);
        name_q.push_back(nm);
        if (!r && o[7]) exp_cnt = exp_cnt + 1;
    endtask

    initial begin : monitor
        logic [7:0]  act, eo;
        logic [31:0] ec;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_o_q.size() > 0) begin
                eo = exp_o_q.pop_front();
                ec = exp_c_q.pop_front();
                nm = name_q.pop_front();
                act = {pc_stall, ifid_stall, idex_stall, idex_hazarded,
                       pipelineFlush, exmem_bubble, mc_go, mc_err};
                checks++;
                if (act !== eo || stall_cnt !== ec) begin
                    errors++;
                    $display("FAIL %s: flags got %b want %b, stall_cnt got %0d want %0d",
                             nm, act, eo, stall_cnt, ec);
                end
            end
        end
    end

    initial begin : stim
        int budget;
        //   name           rst rs1   rs2   u1 u2 rena wa   br req dn  expect
        cyc("reset",        1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_FLUSH);
        cyc("idle",         0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);
        cyc("lu_rs1",       0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, O_LU);
        cyc("lu_after",     0, 5'd5, 5'd0, 1, 0, 0, 5'd5, 0, 0, 0, O_IDLE);
        cyc("lu_rs2",       0, 5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, O_LU);
        cyc("x0_dest",      0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, O_IDLE);
        cyc("rs2_unused",   0, 5'd4, 5'd9, 1, 0, 1, 5'd9, 0, 0, 0, O_IDLE);
        cyc("no_load",      0, 5'd5, 5'd5, 1, 1, 0, 5'd5, 0, 0, 0, O_IDLE);
        cyc("br_wins",      0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0, O_FLUSH);
        cyc("br_stay_run",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);
        // multicycle op: req at c0, done at c4
        cyc("mc_c0_go",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO);
        cyc("mc_c1",        0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_WAIT);
        cyc("mc_c2_ignore", 0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0, O_WAIT);
        cyc("mc_c3",        0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_WAIT);
        cyc("mc_c4_done",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_WAIT);
        cyc("mc_c5_mcdone", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_IDLE);
        cyc("mc_c6_run",    0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, O_IDLE);
        // load-use and branch evaluated in MC_DONE
        cyc("mcd_lu_go",    0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO);
        cyc("mcd_lu_wait",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_WAIT);
        cyc("mcd_lu",       0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0, O_LU);
        cyc("mcd_lu_idle",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);
        cyc("mcd_br_go",    0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO);
        cyc("mcd_br_wait",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_WAIT);
        cyc("mcd_br",       0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0, O_FLUSH);
        cyc("mcd_br_idle",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);
        // done on the last timeout cycle: no error
        cyc("tdone_go",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO);
        for (int i = 0; i < 7; i++)
            cyc("tdone_wait", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_WAIT);
        cyc("tdone_last",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_WAIT);
        cyc("tdone_mcdone", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_IDLE);
        cyc("tdone_noerr",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);
        // timeout abort
        cyc("tout_go",      0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO);
        for (int i = 0; i < 8; i++)
            cyc("tout_wait", 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_WAIT);
        cyc("tout_mcdone",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_ERR);
        cyc("tout_run",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_ERR);
        cyc("tout_sticky",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_ERR);
        // async reset in the middle of MC_WAIT
        cyc("ar_go",        0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO | O_ERR);
        cyc("ar_wait1",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_WAIT | O_ERR);
        cyc("ar_wait2",     0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_WAIT | O_ERR);
        cyc("ar_assert",    1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_FLUSH);
        cyc("ar_hold",      1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_FLUSH);
        cyc("ar_release",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);
        cyc("ar_run_go",    0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_GO);
        cyc("ar_run_wait",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_WAIT);
        cyc("ar_run_mcd",   0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_IDLE);
        cyc("ar_run_idle",  0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_IDLE);

        budget = 20;
        while (exp_o_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_o_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_o_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
